// File: rtl/lcd_wr_engine_pkg.sv
// Shared definitions for the HD44780 write engine: FSM states, LCD command bytes,
// the memory-mapped port address and the long-execution-wait rule.
package lcd_wr_engine_pkg;

  typedef enum logic [2:0] {
    StPwrup  = 3'd0,
    StInitLd = 3'd1,
    StIdle   = 3'd2,
    StSetup  = 3'd3,
    StPulse  = 3'd4,
    StHold   = 3'd5,
    StWait   = 3'd6
  } state_e;

  localparam logic [7:0] CmdFunc8b2l = 8'h38;
  localparam logic [7:0] CmdDispOn   = 8'h0C;
  localparam logic [7:0] CmdClear    = 8'h01;
  localparam logic [7:0] CmdEntryInc = 8'h06;

  // Store writes {rs, byte}; load returns {31'b0, busy}.
  localparam logic [31:0] LcdMemAddr = 32'h0000_7030;

  localparam int unsigned InitLen = 6;
  localparam int unsigned CntW    = 20;

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'b0);
  endfunction

endpackage

// File: rtl/lcd_wr_engine_init_rom.sv
// Power-on init command table: index -> command byte and long-wait flag.
module lcd_wr_engine_init_rom
  import lcd_wr_engine_pkg::*;
(
  input  logic [2:0] idx_i,
  output logic [7:0] cmd_o,
  output logic       long_wait_o
);

  always_comb begin
    cmd_o = 8'h00;
    unique case (idx_i)
      3'd0, 3'd1, 3'd2: cmd_o = CmdFunc8b2l;
      3'd3:             cmd_o = CmdDispOn;
      3'd4:             cmd_o = CmdClear;
      3'd5:             cmd_o = CmdEntryInc;
      default:          cmd_o = 8'h00;
    endcase
    long_wait_o = is_long_cmd(1'b0, cmd_o);
  end

endmodule

// File: rtl/lcd_wr_engine.sv
// HD44780 write engine: runs the power-on init sequence, then strobes single bytes
// from the LSU onto the LCD bus with setup/pulse/hold/exec-wait timing.
module lcd_wr_engine
  import lcd_wr_engine_pkg::*;
#(
  parameter int unsigned PWRUP_CYC     = 750000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned WAIT_CYC      = 2500,
  parameter int unsigned WAIT_LONG_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       busy,
  output logic       init_done,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_dec;
  logic [2:0]        idx_q, idx_d;
  logic              long_q, long_d;
  logic              en_q, en_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        rom_cmd;
  logic              rom_long;

  lcd_wr_engine_init_rom u_init_rom (
    .idx_i       (idx_q),
    .cmd_o       (rom_cmd),
    .long_wait_o (rom_long)
  );

  assign cnt_dec = cnt_q - CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    long_d  = long_q;
    en_d    = 1'b0;
    rs_d    = rs_q;
    data_d  = data_q;
    ready_d = 1'b0;
    done_d  = done_q;

    case (state_q)
      StPwrup: begin
        if (cnt_q == '0) state_d = StInitLd;
        else             cnt_d   = cnt_dec;
      end
      StInitLd: begin
        rs_d    = 1'b0;
        data_d  = rom_cmd;
        long_d  = rom_long;
        idx_d   = idx_q + 3'd1;
        state_d = StSetup;
        cnt_d   = CntW'(SETUP_CYC - 1);
      end
      StIdle: begin
        if (req_valid && ready_q) begin
          rs_d    = req_rs;
          data_d  = req_data;
          long_d  = is_long_cmd(req_rs, req_data);
          state_d = StSetup;
          cnt_d   = CntW'(SETUP_CYC - 1);
        end else begin
          ready_d = 1'b1;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = CntW'(EN_CYC - 1);
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = CntW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_dec;
          en_d  = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StWait;
          cnt_d   = long_q ? CntW'(WAIT_LONG_CYC - 1) : CntW'(WAIT_CYC - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          if (!done_q && (idx_q < 3'(InitLen))) begin
            state_d = StInitLd;
          end else begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: state_d = StPwrup;
    endcase

    busy_d = ~ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StPwrup;
      // The power-up wait is the first timed state, so it starts pre-loaded.
      cnt_q   <= CntW'(PWRUP_CYC - 1);
      idx_q   <= 3'd0;
      long_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      long_q  <= long_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign init_done = done_q;
  assign LCD_EN    = en_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_wr_engine.sv
// Scoreboard bench for lcd_wr_engine: expected bytes are queued when driven and
// compared against strobes captured from the LCD bus.
module tb_lcd_wr_engine;

  localparam int unsigned PW = 10, SU = 2, EN = 3, HO = 2, WT = 5, WL = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, busy, init_done, LCD_EN, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         width;
    bit         stable;
    int         rise_cyc;
  } pulse_t;

  exp_t   exp_q[$];
  pulse_t obs_q[$];
  pulse_t cur, hold_ref;
  bit     en_prev = 1'b0;
  int     hold_left = 0;
  bit     hold_bad = 1'b0;
  bit     rw_bad = 1'b0;

  lcd_wr_engine #(
    .PWRUP_CYC     (PW),
    .SETUP_CYC     (SU),
    .EN_CYC        (EN),
    .HOLD_CYC      (HO),
    .WAIT_CYC      (WT),
    .WAIT_LONG_CYC (WL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .busy      (busy),
    .init_done (init_done),
    .LCD_EN    (LCD_EN),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_DATA  (LCD_DATA)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: captures each EN strobe and watches RS/DATA through pulse and hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev   <= 1'b0;
      hold_left <= 0;
    end else begin
      en_prev <= LCD_EN;
      if (LCD_RW !== 1'b0) rw_bad <= 1'b1;
      if (LCD_EN && !en_prev) begin
        cur <= '{rs: LCD_RS, data: LCD_DATA, width: 1, stable: 1'b1, rise_cyc: cyc};
      end else if (LCD_EN && en_prev) begin
        cur.width <= cur.width + 1;
        if (LCD_RS !== cur.rs || LCD_DATA !== cur.data) cur.stable <= 1'b0;
      end else if (!LCD_EN && en_prev) begin
        obs_q.push_back(cur);
        if (LCD_RS !== cur.rs || LCD_DATA !== cur.data) hold_bad <= 1'b1;
        hold_ref  <= cur;
        hold_left <= HO - 1;
      end else if (hold_left > 0) begin
        hold_left <= hold_left - 1;
        if (LCD_RS !== hold_ref.rs || LCD_DATA !== hold_ref.data) hold_bad <= 1'b1;
      end
    end
  end

  task automatic accept(input logic rs, input logic [7:0] d, output int acc, output bit ok);
    ok  = 1'b0;
    acc = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        acc = cyc + 1;
        exp_q.push_back('{rs: rs, data: d});
        @(posedge clk);
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_init();
    logic [7:0] cmds [6];
    cmds = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 6; i++) exp_q.push_back('{rs: 1'b0, data: cmds[i]});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (LCD_EN !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", LCD_EN); end
    checks++;
    if (LCD_RS !== 1'b0) begin failures++; $display("FAIL rst_rs got=%b exp=0", LCD_RS); end
    checks++;
    if (LCD_RW !== 1'b0) begin failures++; $display("FAIL rst_rw got=%b exp=0", LCD_RW); end
    checks++;
    if (LCD_DATA !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", LCD_DATA); end
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++;
    if (init_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", init_done); end
  endtask

  // Releases reset (req_valid low) and checks the full init replay.
  task automatic test_init();
    int     rises[6];
    int     k, i;
    pulse_t p;
    exp_t   e;
    exp_q.delete();
    obs_q.delete();
    push_init();
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (i = 0; i < 400 && !init_done; i++) @(negedge clk);
    checks++;
    if (!init_done) begin
      failures++;
      $display("FAIL init_timeout got=%b exp=1 after %0d cycles", init_done, i);
    end
    checks++;
    if (obs_q.size() != 6) begin
      failures++;
      $display("FAIL init_count got=%0d exp=6", obs_q.size());
    end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      p = obs_q.pop_front();
      e = exp_q.pop_front();
      if (k < 6) rises[k] = p.rise_cyc;
      checks++;
      if (p.rs !== e.rs || p.data !== e.data || p.width != EN || !p.stable) begin
        failures++;
        $display("FAIL init_byte%0d got=%b/%h/w%0d/s%0d exp=%b/%h/w%0d/s1", k, p.rs, p.data,
                 p.width, p.stable, e.rs, e.data, EN);
      end
      k++;
    end
    if (k == 6) begin
      checks++;
      if (rises[4] - rises[3] != 1 + SU + EN + HO + WT) begin
        failures++;
        $display("FAIL init_gap_short got=%0d exp=%0d", rises[4] - rises[3], 1 + SU + EN + HO + WT);
      end
      checks++;
      if (rises[5] - rises[4] != 1 + SU + EN + HO + WL) begin
        failures++;
        $display("FAIL init_gap_long got=%0d exp=%0d", rises[5] - rises[4], 1 + SU + EN + HO + WL);
      end
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_idle got=ready%b/busy%b/done%b exp=1/0/1", req_ready, busy, init_done);
    end
  endtask

  task automatic test_transfer(input logic rs, input logic [7:0] d, input int exp_n,
                               input string nm);
    int     acc, n;
    bit     ok, got;
    pulse_t p;
    exp_t   e;
    obs_q.delete();
    accept(rs, d, acc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_accept got=timeout exp=accepted", nm);
      req_valid = 1'b0;
      return;
    end
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid = 1'b0;
        checks++;
        if (LCD_RS !== rs || LCD_DATA !== d || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s_latch got=%b/%h/busy%b exp=%b/%h/busy1", nm, LCD_RS, LCD_DATA, busy,
                   rs, d);
        end
      end
      if (req_ready) got = 1'b1;
    end
    checks++;
    if (!got || n != exp_n) begin
      failures++;
      $display("FAIL %s_ready_latency got=%0d exp=%0d", nm, n, exp_n);
    end
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL %s_pulses got=%0d exp=1", nm, obs_q.size());
    end else begin
      p = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (p.rs !== e.rs || p.data !== e.data || p.width != EN || !p.stable ||
          p.rise_cyc - acc != SU) begin
        failures++;
        $display("FAIL %s_strobe got=%b/%h/w%0d/s%0d/d%0d exp=%b/%h/w%0d/s1/d%0d", nm, p.rs,
                 p.data, p.width, p.stable, p.rise_cyc - acc, e.rs, e.data, EN, SU);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int     a1, a2, n;
    bit     ok1, ok2;
    pulse_t p[2];
    exp_t   e;
    obs_q.delete();
    exp_q.delete();
    accept(1'b1, 8'h48, a1, ok1);
    accept(1'b1, 8'h49, a2, ok2);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (!ok1 || !ok2 || a2 - a1 != 1 + SU + EN + HO + WT) begin
      failures++;
      $display("FAIL b2b_accept_gap got=%0d ok=%0d%0d exp=%0d", a2 - a1, ok1, ok2,
               1 + SU + EN + HO + WT);
    end
    for (n = 0; n < 100 && !req_ready; n++) @(negedge clk);
    checks++;
    if (obs_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        p[i] = obs_q.pop_front();
        e    = exp_q.pop_front();
        checks++;
        if (p[i].rs !== e.rs || p[i].data !== e.data || p[i].width != EN || !p[i].stable) begin
          failures++;
          $display("FAIL b2b_byte%0d got=%b/%h/w%0d/s%0d exp=%b/%h/w%0d/s1", i, p[i].rs,
                   p[i].data, p[i].width, p[i].stable, e.rs, e.data, EN);
        end
      end
      checks++;
      if (p[1].rise_cyc - p[0].rise_cyc != a2 - a1) begin
        failures++;
        $display("FAIL b2b_rise_gap got=%0d exp=%0d", p[1].rise_cyc - p[0].rise_cyc, a2 - a1);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_transfer();
    int acc, i;
    bit ok;
    accept(1'b1, 8'h55, acc, ok);
    @(negedge clk);
    req_valid = 1'b0;
    for (i = 0; i < 50 && !LCD_EN; i++) @(negedge clk);
    checks++;
    if (!LCD_EN) begin failures++; $display("FAIL midrst_en_seen got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (LCD_EN !== 1'b0 || LCD_RS !== 1'b0 || LCD_DATA !== 8'h00 || req_ready !== 1'b0 ||
        busy !== 1'b1 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs got=en%b rs%b d%h rdy%b busy%b done%b exp=0 0 00 0 1 0",
               LCD_EN, LCD_RS, LCD_DATA, req_ready, busy, init_done);
    end
    repeat (2) @(negedge clk);
    test_init();
  endtask

  task automatic test_valid_during_init();
    int     i, n, k;
    bit     seen, prev_done;
    pulse_t p;
    exp_t   e;
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    push_init();
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h5A;
    #2 rst_n = 1'b1;
    seen      = 1'b0;
    prev_done = 1'b0;
    for (i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (req_ready) seen = 1'b1;
      else prev_done = init_done;
    end
    checks++;
    if (!seen || init_done !== 1'b1 || prev_done !== 1'b0 || obs_q.size() != 6) begin
      failures++;
      $display("FAIL vinit_first_idle got=seen%0d done%b prev%b pulses%0d exp=1 1 0 6", seen,
               init_done, prev_done, obs_q.size());
    end
    exp_q.push_back('{rs: 1'b1, data: 8'h5A});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (n = 1; n < 100 && !req_ready; n++) @(negedge clk);
    checks++;
    if (n != 1 + SU + EN + HO + WT) begin
      failures++;
      $display("FAIL vinit_ready_latency got=%0d exp=%0d", n, 1 + SU + EN + HO + WT);
    end
    checks++;
    if (obs_q.size() != 7) begin
      failures++;
      $display("FAIL vinit_pulses got=%0d exp=7", obs_q.size());
    end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      p = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (p.rs !== e.rs || p.data !== e.data || p.width != EN) begin
        failures++;
        $display("FAIL vinit_byte%0d got=%b/%h/w%0d exp=%b/%h/w%0d", k, p.rs, p.data, p.width,
                 e.rs, e.data, EN);
      end
      k++;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_init();
    test_transfer(1'b1, 8'h41, 1 + SU + EN + HO + WT, "data41");
    test_transfer(1'b0, 8'h01, 1 + SU + EN + HO + WL, "clear");
    test_transfer(1'b0, 8'h02, 1 + SU + EN + HO + WL, "home");
    test_transfer(1'b1, 8'h01, 1 + SU + EN + HO + WT, "data01");
    test_transfer(1'b0, 8'h04, 1 + SU + EN + HO + WT, "cmd04");
    test_back_to_back();
    test_reset_mid_transfer();
    test_valid_during_init();
    checks++;
    if (hold_bad || rw_bad) begin
      failures++;
      $display("FAIL bus_integrity got=hold_bad%0d rw_bad%0d exp=0 0", hold_bad, rw_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
